// File: rtl/scheme_player.sv
// Stores the latest flag and 48-bit scheme seen from the demodulator and, on a
// trigger frame, plays the scheme MSB-first as a timed per-bit modulation select.
module scheme_player #(
    parameter int BIT_TICKS = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  ord,
    input  logic [1:0]  ctg,
    input  logic [7:0]  cur_flag,
    input  logic [47:0] cur_scheme,
    output logic        working,
    output logic        mod_en,
    output logic        mod_bit,
    output logic [5:0]  bit_idx,
    output logic        done,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0]  CTG_TRIGGER = 2'b01;
    localparam logic [1:0]  CTG_FLAG    = 2'b10;
    localparam logic [1:0]  CTG_SCHEME  = 2'b11;
    localparam logic [15:0] PRESC_MAX   = 16'(BIT_TICKS - 1);

    state_t       state, state_nx;
    logic [1:0]   ord_prev;
    logic [7:0]   flag_r, flag_nx;
    logic [47:0]  sched_r, sched_nx;
    logic [15:0]  presc_q, presc_nx;
    logic [5:0]   unit_q, unit_nx;
    logic [1:0]   pass_q, pass_nx;
    logic [5:0]   idx_q, idx_nx;
    logic         bit_q, bit_nx;
    logic         working_q;

    logic         event_seen;
    logic [6:0]   period;
    logic [2:0]   passes;
    logic         presc_last;
    logic         unit_last;
    logic         pass_last;

    // One frame per change of the demodulator counter, in any state.
    assign event_seen = (ord != ord_prev);
    assign period     = {1'b0, flag_r[5:0]} + 7'd1;
    assign passes     = {1'b0, flag_r[7:6]} + 3'd1;
    assign presc_last = (presc_q == PRESC_MAX);
    assign unit_last  = ({1'b0, unit_q} == (period - 7'd1));
    assign pass_last  = ({1'b0, pass_q} == (passes - 3'd1));

    always_comb begin
        state_nx = state;
        flag_nx  = flag_r;
        sched_nx = sched_r;
        presc_nx = presc_q;
        unit_nx  = unit_q;
        pass_nx  = pass_q;
        idx_nx   = idx_q;
        bit_nx   = bit_q;
        case (state)
            IDLE: begin
                if (event_seen) begin
                    if (ctg == CTG_FLAG) begin
                        flag_nx = cur_flag;
                    end else if (ctg == CTG_SCHEME) begin
                        sched_nx = cur_scheme;
                        state_nx = READY;
                    end
                end
            end
            READY: begin
                if (event_seen) begin
                    if (ctg == CTG_FLAG) begin
                        flag_nx = cur_flag;
                    end else if (ctg == CTG_SCHEME) begin
                        sched_nx = cur_scheme;
                    end else if (ctg == CTG_TRIGGER) begin
                        state_nx = PLAY;
                        presc_nx = 16'd0;
                        unit_nx  = 6'd0;
                        pass_nx  = 2'd0;
                        idx_nx   = 6'd47;
                        bit_nx   = sched_r[47];
                    end
                end
            end
            PLAY: begin
                // Events are deliberately ignored here; flag and scheme stay frozen.
                presc_nx = presc_q + 16'd1;
                if (presc_last) begin
                    presc_nx = 16'd0;
                    unit_nx  = unit_q + 6'd1;
                    if (unit_last) begin
                        unit_nx = 6'd0;
                        if (idx_q != 6'd0) begin
                            idx_nx = idx_q - 6'd1;
                            bit_nx = sched_r[idx_q - 6'd1];
                        end else if (!pass_last) begin
                            pass_nx = pass_q + 2'd1;
                            idx_nx  = 6'd47;
                            bit_nx  = sched_r[47];
                        end else begin
                            state_nx = DONE;
                            idx_nx   = 6'd0;
                            bit_nx   = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                state_nx = READY;
                idx_nx   = 6'd0;
                bit_nx   = 1'b0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ord_prev  <= 2'd0;
            flag_r    <= 8'd0;
            sched_r   <= 48'd0;
            presc_q   <= 16'd0;
            unit_q    <= 6'd0;
            pass_q    <= 2'd0;
            idx_q     <= 6'd0;
            bit_q     <= 1'b0;
            working_q <= 1'b0;
        end else begin
            state     <= state_nx;
            ord_prev  <= ord;
            flag_r    <= flag_nx;
            sched_r   <= sched_nx;
            presc_q   <= presc_nx;
            unit_q    <= unit_nx;
            pass_q    <= pass_nx;
            idx_q     <= idx_nx;
            bit_q     <= bit_nx;
            working_q <= (state_nx == PLAY);
        end
    end

    assign working = working_q;
    assign mod_en  = working_q;
    assign mod_bit = bit_q;
    assign bit_idx = idx_q;
    assign done    = (state == DONE);
    assign ready   = (state == READY);

endmodule

// File: tb/tb_scheme_player.sv
// Directed and randomized checks of scheme_player against a queue-based model of
// the expected per-clock modulation output.
module tb_scheme_player;

    localparam int BT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ord;
    logic [1:0]  ctg;
    logic [7:0]  cur_flag;
    logic [47:0] cur_scheme;
    logic        working;
    logic        mod_en;
    logic        mod_bit;
    logic [5:0]  bit_idx;
    logic        done;
    logic        ready;

    scheme_player #(.BIT_TICKS(BT)) dut (
        .clock      (clock),
        .reset      (reset),
        .ord        (ord),
        .ctg        (ctg),
        .cur_flag   (cur_flag),
        .cur_scheme (cur_scheme),
        .working    (working),
        .mod_en     (mod_en),
        .mod_bit    (mod_bit),
        .bit_idx    (bit_idx),
        .done       (done),
        .ready      (ready)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: one entry {mod_bit, bit_idx} per expected PLAY clock
    logic [6:0]  exp_q[$];
    logic [7:0]  m_flag;
    logic [47:0] m_sched;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({working, mod_en, done, ready, mod_bit, bit_idx});
    endfunction

    // Driver: present one frame; model tracks loads (only used outside PLAY)
    task automatic send(input logic [1:0] c, input logic [7:0] f, input logic [47:0] s);
        ctg        = c;
        cur_flag   = f;
        cur_scheme = s;
        ord        = ord + 2'd1;
        if (c == 2'b10) m_flag = f;
        if (c == 2'b11) m_sched = s;
        tick();
    endtask

    task automatic build_model();
        int per;
        int pas;
        per = int'(m_flag[5:0]) + 1;
        pas = int'(m_flag[7:6]) + 1;
        exp_q.delete();
        for (int p = 0; p < pas; p++)
            for (int b = 47; b >= 0; b--)
                for (int t = 0; t < per * BT; t++)
                    exp_q.push_back({m_sched[b], 6'(b)});
    endtask

    // Called at the first PLAY clock; walks the scoreboard, then checks DONE and READY.
    task automatic run_play(input string tag, input int inject_at, output int wraps);
        int cyc;
        logic [5:0] prev_idx;
        logic [6:0] e;
        cyc      = 0;
        wraps    = 0;
        prev_idx = 6'd47;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, outs(), 64'({1'b1, 1'b1, 1'b0, 1'b0, e}));
            if (prev_idx == 6'd0 && bit_idx == 6'd47) wraps++;
            prev_idx = bit_idx;
            if (cyc == inject_at) begin
                ctg        = 2'b11;
                cur_scheme = ~m_sched;
                ord        = ord + 2'd1;
            end
            if (cyc == inject_at + 3) begin
                ctg = 2'b01;
                ord = ord + 2'd1;
            end
            tick();
            cyc++;
        end
        check({tag, "_done"}, outs(), 64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0}));
        tick();
        check({tag, "_ready"}, outs(), 64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));
    endtask

    initial begin
        int wraps;
        logic [7:0]  f;
        logic [47:0] s;

        reset      = 1'b1;
        ord        = 2'd0;
        ctg        = 2'd0;
        cur_flag   = 8'd0;
        cur_scheme = 48'd0;
        m_flag     = 8'd0;
        m_sched    = 48'd0;
        #1;
        check("reset_outs", outs(), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_outs", outs(), 64'd0);

        // Trigger with no scheme loaded
        send(2'b01, 8'd0, 48'd0);
        for (int i = 0; i < 4; i++) check("trig_no_scheme", outs(), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("trig_no_scheme_hold", 64'({working, ready}), 64'd0);
        end

        // Basic playback, flag at reset value
        send(2'b11, 8'd0, 48'hA00000000001);
        check("basic_loaded_ready", outs(), 64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));
        build_model();
        check("basic_len", 64'(exp_q.size()), 64'd96);
        send(2'b01, 8'd0, 48'd0);
        run_play("basic", -100, wraps);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_self_replay", 64'({working, ready}), 64'b01);
        end

        // Flag timing: period 3, passes 3
        send(2'b10, 8'b10_000010, 48'd0);
        send(2'b11, 8'd0, 48'hFFFF00000000);
        build_model();
        check("flag_len", 64'(exp_q.size()), 64'd864);
        send(2'b01, 8'd0, 48'd0);
        run_play("flag", -100, wraps);
        check("flag_wraps", 64'(wraps), 64'd2);

        // Events during PLAY are ignored, then the old scheme replays
        build_model();
        send(2'b01, 8'd0, 48'd0);
        run_play("ignore", 40, wraps);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ignore_no_extra", 64'({working, ready}), 64'b01);
        end
        build_model();
        send(2'b01, 8'd0, 48'd0);
        run_play("replay_old", -100, wraps);

        // Randomized loads and playbacks
        for (int it = 0; it < 6; it++) begin
            f = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            s = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                send(2'b10, f, 48'd0);
                send(2'b11, 8'd0, s);
            end else begin
                send(2'b11, 8'd0, s);
                send(2'b10, f, 48'd0);
            end
            if ($urandom_range(0, 1) == 1) send(2'b00, 8'hFF, ~s);
            build_model();
            send(2'b01, 8'd0, 48'd0);
            run_play("random", int'($urandom_range(0, 60)), wraps);
        end

        // Reset in the middle of playback at bit 20
        send(2'b10, 8'd0, 48'd0);
        send(2'b11, 8'd0, 48'h123456789ABC);
        send(2'b01, 8'd0, 48'd0);
        for (int i = 0; i < 200 && bit_idx != 6'd20; i++) tick();
        check("reach_bit20", 64'({working, bit_idx}), 64'({1'b1, 6'd20}));
        ord   = 2'd0;
        ctg   = 2'd0;
        reset = 1'b1;
        #1;
        check("midplay_reset_outs", outs(), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        send(2'b01, 8'd0, 48'd0);
        for (int i = 0; i < 6; i++) begin
            check("trig_after_reset", outs(), 64'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scheme_player.md
# scheme_player

Downstream stage of the downlink demodulator. Watches the demodulator's frame counter and category outputs, stores the most recent 8-bit flag and 48-bit scheme, and on a trigger frame plays the scheme out MSB-first as a timed per-bit modulation select for the backscatter modulator. While playing it asserts `working`, which feeds the demodulator's `working` input and holds its decoder in reset.

## Interface
- `BIT_TICKS`, default 50: clocks per timing unit. Legal range 1..65535.
- `clock`, in, 1: system clock, all state on rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `ord`, in, 2: demodulator frame counter. Any change is one new frame.
- `ctg`, in, 2: demodulator frame category.
  - 01 = trigger.
  - 10 = flag.
  - 11 = scheme.
- `cur_flag`, in, 8: last decoded flag. Valid when `ctg`=10 changes `ord`.
- `cur_scheme`, in, 48: last decoded scheme. Valid when `ctg`=11 changes `ord`.
- `working`, out, 1: high while in PLAY.
- `mod_en`, out, 1: high while in PLAY. Identical to `working`.
- `mod_bit`, out, 1: scheme bit currently being played. 0 outside PLAY.
- `bit_idx`, out, 6: index of the bit currently being played, 47..0. 0 outside PLAY.
- `done`, out, 1: one-clock pulse at the end of playback.
- `ready`, out, 1: a scheme is loaded and no playback is running.

## Operation
- Event detection:
  - `ord_prev` (2 bits) loads `ord` every clock. Reset value is 0.
  - An event exists in a cycle when `ord != ord_prev`.
  - At most one event is processed per clock.
  - Events are evaluated in every state. `ord_prev` updates in every state, so a change seen during PLAY never produces a late event.
- Stored registers:
  - `flag_r` (8 bits), reset value 0.
  - `sched_r` (48 bits), reset value 0.
  - `period = flag_r[5:0] + 1`, giving 1..64 units. Compute in 7 bits; no overflow.
  - `passes = flag_r[7:6] + 1`, giving 1..4.
- States: IDLE (reset state, no scheme), READY, PLAY, DONE.
- IDLE:
  - ctg=10 event: load `flag_r`.
  - ctg=11 event: load `sched_r` and go to READY.
  - ctg=01 event: ignored, because there is no scheme.
  - ctg=00 event: ignored.
- READY:
  - ctg=10 event: load `flag_r`.
  - ctg=11 event: replace `sched_r`.
  - ctg=01 event: go to PLAY. Set `bit_idx`=47, prescaler=0, unit counter=0, pass counter=0, and `mod_bit`=`sched_r[47]`.
- PLAY:
  - All events are ignored; `flag_r` and `sched_r` are frozen.
  - The prescaler counts 0..BIT_TICKS-1.
  - On prescaler wrap, the unit counter advances 0..period-1.
  - On unit wrap with `bit_idx`>0: decrement `bit_idx` and set `mod_bit`=`sched_r[bit_idx-1]`.
  - On unit wrap with `bit_idx`=0 and passes remaining: increment the pass counter, set `bit_idx`=47 and `mod_bit`=`sched_r[47]`.
  - On unit wrap with `bit_idx`=0 on the last pass: go to DONE.
- DONE:
  - Lasts one clock with `done`=1.
  - Unconditionally goes to READY. The scheme is retained for re-trigger.
  - Any event arriving in DONE is ignored.
- Output levels:
  - `working` = `mod_en` = (state==PLAY). Registered.
  - `ready` = (state==READY).
  - Outside PLAY: `mod_bit`=0 and `bit_idx`=0.
- Reset, including mid-playback: all outputs go to 0 asynchronously and the state goes to IDLE. The stored scheme is lost.

## Timing
- Reset value of every output is 0.
- Event latency: if `ord` changes at edge k, the event is acted on at edge k+1. For a trigger, `working`, `mod_en`, `bit_idx`=47 and `mod_bit` are valid from edge k+1.
- Bit duration: exactly `period`×`BIT_TICKS` clocks per bit, with no gap between bits or between passes.
- Total PLAY length: 48×`period`×`BIT_TICKS`×`passes` clocks.
- End of playback: `working` falls at the same edge that `done` rises. `ready` rises one clock later.
- Flag/scheme loads: take effect at edge k+1 after the `ord` change. A trigger arriving after the load plays the new values.

## Test plan
- Trigger without a scheme:
  - Stimulus: after reset, `ord` 0→1 with `ctg`=01.
  - Required: state stays IDLE; `working`=0 and `ready`=0 throughout.
- Basic playback:
  - Stimulus: `BIT_TICKS`=2; scheme event with `cur_scheme`=48'hA00000000001, then a trigger event.
  - Required: `working` high for exactly 96 clocks.
  - Required `mod_bit` sequence, 2 clocks per bit: 1,0,1, then 44 zeros, then 1.
  - Required: `done` pulses once, then `ready`=1.
- Flag timing:
  - Stimulus: `BIT_TICKS`=2; flag 8'b10_000010 (period 3, passes 3); scheme 48'hFFFF00000000; trigger.
  - Required: each bit held 6 clocks; `working` high for 864 clocks.
  - Required: `bit_idx` wraps 0→47 twice.
- Ignore during play:
  - Stimulus: during PLAY, step `ord` with `ctg`=11 (new scheme) and with `ctg`=01.
  - Required: playback is unchanged, and after `done` the old scheme is still stored.
  - Required: one further trigger replays the old scheme. No extra playback starts on its own.
- Reset mid-play:
  - Stimulus: assert `reset` at bit 20.
  - Required: all outputs 0 immediately, state IDLE.
  - Required: a subsequent trigger, with no scheme loaded, is ignored.
